// File: rtl/imm_decode_if.sv
// Handshake bundle around the immediate decode stage: producer offer (in_*) and
// decoded head entry toward the consumer (out_*, imm/fmt/illegal/tag).
interface imm_decode_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport master (
        output in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_decode_stage.sv
// RISC-V style immediate decoder feeding a 2-entry FIFO; outputs come straight
// from FIFO registers so there is no combinational path from instr_i to imm_o.
module imm_decode_stage #(
    parameter int         XLEN       = 32,
    parameter int         TAG_W      = 8,
    parameter logic [6:0] PIM_OPCODE = 7'b0001011,
    parameter bit         PIM_FMT_I  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    imm_decode_if.slave bus
);
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_PIM   = 3'd7;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    localparam int ENTRY_W = TAG_W + 1 + 3 + XLEN;

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // Every immediate layout fits in 32 bits; widening to XLEN is a plain sign extension.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [31:0]        instr_s;
    logic [6:0]         opcode_s;
    logic               is_shift_s;
    logic [31:0]        imm_i_s, imm_st_s, imm_b_s, imm_j_s, imm_u_s;
    logic [XLEN-1:0]    imm_s;
    logic [2:0]         fmt_s;
    logic               illegal_s;
    logic [ENTRY_W-1:0] entry_s, head_s;
    logic               push_s, pop_s;

    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q, count_d;

    assign instr_s    = bus.instr_i;
    assign opcode_s   = instr_s[6:0];
    assign is_shift_s = (instr_s[14:12] == 3'b001) || (instr_s[14:12] == 3'b101);
    assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_st_s   = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    assign imm_u_s    = {instr_s[31:12], 12'd0};

    // Immediate decode of the offered instruction; PIM is checked first so it may alias any opcode.
    always_comb begin
        imm_s     = {XLEN{1'b0}};
        fmt_s     = FMT_NONE;
        illegal_s = 1'b1;
        if (opcode_s == PIM_OPCODE) begin
            fmt_s     = FMT_PIM;
            illegal_s = 1'b0;
            if (PIM_FMT_I) begin
                imm_s = sext32(imm_i_s);
            end else begin
                imm_s = sext32(imm_st_s);
            end
        end else begin
            case (opcode_s)
                OPC_LOAD, OPC_JALR: begin
                    imm_s = sext32(imm_i_s); fmt_s = FMT_I; illegal_s = 1'b0;
                end
                OPC_STORE: begin
                    imm_s = sext32(imm_st_s); fmt_s = FMT_S; illegal_s = 1'b0;
                end
                OPC_BRANCH: begin
                    imm_s = sext32(imm_b_s); fmt_s = FMT_B; illegal_s = 1'b0;
                end
                OPC_JAL: begin
                    imm_s = sext32(imm_j_s); fmt_s = FMT_J; illegal_s = 1'b0;
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_s = sext32(imm_u_s); fmt_s = FMT_U; illegal_s = 1'b0;
                end
                OPC_OPIMM: begin
                    if (is_shift_s) begin
                        fmt_s = FMT_SHAMT;
                        if (XLEN == 64) begin
                            imm_s = XLEN'(instr_s[25:20]); illegal_s = 1'b0;
                        end else begin
                            imm_s = XLEN'(instr_s[24:20]); illegal_s = instr_s[25];
                        end
                    end else begin
                        imm_s = sext32(imm_i_s); fmt_s = FMT_I; illegal_s = 1'b0;
                    end
                end
                OPC_OPIMM32: begin
                    // Word-sized ops only exist on a 64-bit datapath.
                    if (XLEN == 64) begin
                        if (is_shift_s) begin
                            imm_s = XLEN'(instr_s[24:20]); fmt_s = FMT_SHAMT; illegal_s = instr_s[25];
                        end else begin
                            imm_s = sext32(imm_i_s); fmt_s = FMT_I; illegal_s = 1'b0;
                        end
                    end else begin
                        imm_s = {XLEN{1'b0}}; fmt_s = FMT_NONE; illegal_s = 1'b1;
                    end
                end
                default: begin
                    imm_s = {XLEN{1'b0}}; fmt_s = FMT_NONE; illegal_s = 1'b1;
                end
            endcase
        end
    end

    assign entry_s = {bus.tag_i, illegal_s, fmt_s, imm_s};
    assign push_s  = bus.in_valid_i && (count_q != 2'd2);
    assign pop_s   = bus.out_ready_i && (count_q != 2'd0);

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= {ENTRY_W{1'b0}};
            mem_q[1] <= {ENTRY_W{1'b0}};
        end else if (flush_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head_s          = mem_q[rd_ptr_q];
    assign bus.in_ready_o  = (count_q != 2'd2);
    assign bus.out_valid_o = (count_q != 2'd0);
    assign bus.imm_o       = head_s[XLEN-1:0];
    assign bus.fmt_o       = head_s[XLEN+2:XLEN];
    assign bus.illegal_o   = head_s[XLEN+3];
    assign bus.tag_o       = head_s[ENTRY_W-1:XLEN+4];
endmodule
